// File: rtl/sprint1_pkg.sv
// sprint1_pkg
//   Shared definitions for the Sprint 1 ROM load path: loader state
//   encoding, ROM region indices and load-error bit positions.
package sprint1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } ld_state_t;

    // ROM region indices (bit position in the one-hot write strobe)
    localparam int RGN_PROG    = 0;
    localparam int RGN_PROG_HI = 1;
    localparam int RGN_GFX     = 2;
    localparam int RGN_SYNC    = 3;
    localparam int NUM_RGN     = 4;

    // load_err bit positions
    localparam int LOAD_ERR_SHORT = 0;
    localparam int LOAD_ERR_OVF   = 1;

endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode
//   Combinational base compare that maps a flat image byte address onto one
//   of four consecutive ROM regions.
//   Ports:
//     addr_i   - flat image byte address
//     sel_o    - one-hot region select (bit index = RGN_* constant)
//     offset_o - byte offset of addr_i within the selected region
//   Region 3 is open-ended; the caller is responsible for range-checking
//   against the image size.
module rom_region_decode
    import sprint1_pkg::*;
#(
    parameter int          ADDR_W  = 17,
    parameter int unsigned R1_BASE = 'h02000,
    parameter int unsigned R2_BASE = 'h03000,
    parameter int unsigned R3_BASE = 'h03800
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [NUM_RGN-1:0] sel_o,
    output logic [ADDR_W-1:0]  offset_o
);

    localparam logic [ADDR_W-1:0] B1 = ADDR_W'(R1_BASE);
    localparam logic [ADDR_W-1:0] B2 = ADDR_W'(R2_BASE);
    localparam logic [ADDR_W-1:0] B3 = ADDR_W'(R3_BASE);

    always_comb begin
        sel_o    = '0;
        offset_o = addr_i;
        if (addr_i < B1) begin
            sel_o[RGN_PROG] = 1'b1;
        end else if (addr_i < B2) begin
            sel_o[RGN_PROG_HI] = 1'b1;
            offset_o           = addr_i - B1;
        end else if (addr_i < B3) begin
            sel_o[RGN_GFX] = 1'b1;
            offset_o       = addr_i - B2;
        end else begin
            sel_o[RGN_SYNC] = 1'b1;
            offset_o        = addr_i - B3;
        end
    end

endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Sits between hps_io and the Sprint 1 core. Splits the ioctl download
//   stream into per-region ROM writes and holds the core in reset while a
//   load is in progress plus HOLD_CYCLES afterwards.
//   Ports:
//     CLK, reset          - clock, synchronous active-high reset
//     rst_req             - user/OSD reset request (level)
//     dl, dl_wr           - ioctl_download, ioctl_wr strobe
//     dl_addr, dl_data    - ioctl_addr, ioctl_dout
//     rom_we              - one-hot region write strobe (registered)
//     rom_addr, rom_data  - region byte offset and write data
//     core_reset          - registered active-high core reset
//     load_done           - a complete, error-free image has been loaded
//     load_err            - [0] short image, [1] write beyond image size
//     byte_cnt            - accepted writes in the current/last load
module rom_load_sequencer
    import sprint1_pkg::*;
#(
    parameter int          ADDR_W       = 17,
    parameter int unsigned R1_BASE      = 'h02000,
    parameter int unsigned R2_BASE      = 'h03000,
    parameter int unsigned R3_BASE      = 'h03800,
    parameter int unsigned IMG_BYTES    = 'h04000,
    parameter int          HOLD_CYCLES  = 1024,
    parameter bit          REQUIRE_LOAD = 1'b1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              rst_req,
    input  logic              dl,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic [3:0]        rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              core_reset,
    output logic              load_done,
    output logic [1:0]        load_err,
    output logic [ADDR_W:0]   byte_cnt
);

    localparam int              HCW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    // One bit wider than the address so an image filling the whole address
    // space still compares correctly.
    localparam logic [ADDR_W:0] IMG_W     = (ADDR_W + 1)'(IMG_BYTES);
    localparam logic [ADDR_W:0] CNT_MAX   = '1;

    ld_state_t           state_q, state_d;
    logic [HCW-1:0]      hold_q, hold_d;
    logic [3:0]          we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                done_q, done_d;
    logic [1:0]          err_q, err_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                core_rst_q, core_rst_d;

    logic [NUM_RGN-1:0]  dec_sel;
    logic [ADDR_W-1:0]   dec_off;
    logic                in_range;

    rom_region_decode #(
        .ADDR_W  (ADDR_W),
        .R1_BASE (R1_BASE),
        .R2_BASE (R2_BASE),
        .R3_BASE (R3_BASE)
    ) u_dec (
        .addr_i   (dl_addr),
        .sel_o    (dec_sel),
        .offset_o (dec_off)
    );

    assign in_range = {1'b0, dl_addr} < IMG_W;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (dl) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                end else if (!REQUIRE_LOAD) begin
                    // No image needed: release the core after the settle time.
                    if (hold_q == HOLD_LAST) state_d = RUN;
                    else                     hold_d  = hold_q + 1'b1;
                end
            end
            LOAD: begin
                if (!dl) begin
                    // A write coincident with the falling dl is dropped here.
                    state_d = HOLD;
                    hold_d  = '0;
                    if (cnt_q < IMG_W)          err_d[LOAD_ERR_SHORT] = 1'b1;
                    else if (!err_q[LOAD_ERR_OVF]) done_d            = 1'b1;
                end else if (dl_wr) begin
                    if (in_range) begin
                        we_d   = dec_sel;
                        addr_d = dec_off;
                        data_d = dl_data;
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    end else begin
                        err_d[LOAD_ERR_OVF] = 1'b1;
                    end
                end
            end
            HOLD, RUN: begin
                if (dl) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                end else if (state_q == HOLD) begin
                    if (hold_q == HOLD_LAST) state_d = RUN;
                    else                     hold_d  = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Built from next-state so the reset rises the cycle after dl rises
        // and falls on the first RUN cycle.
        core_rst_d = rst_req | (state_d != RUN) | (REQUIRE_LOAD & ~done_d);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            we_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
            cnt_q      <= '0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign rom_we     = we_q;
    assign rom_addr   = addr_q;
    assign rom_data   = data_q;
    assign core_reset = core_rst_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign byte_cnt   = cnt_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Testbench for rom_load_sequencer: directed loads from the test plan plus
// randomized loads, all checked every cycle against a behavioural model.
module tb_rom_load_sequencer;

    localparam int ADDR_W = 17;
    localparam int IMG    = 'h4000;
    localparam int B1     = 'h2000;
    localparam int B2     = 'h3000;
    localparam int B3     = 'h3800;
    localparam int HOLD   = 1024;

    logic              CLK = 1'b0;
    logic              reset, rst_req, dl, dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic [3:0]        rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              core_reset, load_done;
    logic [1:0]        load_err;
    logic [ADDR_W:0]   byte_cnt;

    always #5 CLK = ~CLK;

    rom_load_sequencer #(
        .ADDR_W       (ADDR_W),
        .R1_BASE      (B1),
        .R2_BASE      (B2),
        .R3_BASE      (B3),
        .IMG_BYTES    (IMG),
        .HOLD_CYCLES  (HOLD),
        .REQUIRE_LOAD (1'b1)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .rst_req    (rst_req),
        .dl         (dl),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .byte_cnt   (byte_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int rcnt[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_age counts clock edges since the load ended; the core may run once
    // HOLD edges have passed with no new load and a good image present.
    bit       m_load;
    int       m_age;
    int       m_cnt;
    bit [1:0] m_err;
    bit       m_done;
    bit [3:0] e_we;
    int       e_addr, e_data;
    bit       e_core;

    always @(posedge CLK) begin
        e_we = 4'd0;
        if (reset) begin
            m_load = 0; m_age = -1; m_cnt = 0; m_err = 0; m_done = 0;
            e_addr = 0; e_data = 0; e_core = 1;
        end else begin
            if (m_load) begin
                if (!dl) begin
                    m_load = 0;
                    m_age  = 0;
                    if (m_cnt < IMG)  m_err[0] = 1;
                    else if (!m_err[1]) m_done = 1;
                end else if (dl_wr) begin
                    if (int'(dl_addr) < IMG) begin
                        int a;
                        a = int'(dl_addr);
                        m_cnt++;
                        if (a < B1)      begin e_we = 4'b0001; e_addr = a;      end
                        else if (a < B2) begin e_we = 4'b0010; e_addr = a - B1; end
                        else if (a < B3) begin e_we = 4'b0100; e_addr = a - B2; end
                        else             begin e_we = 4'b1000; e_addr = a - B3; end
                        e_data = int'(dl_data);
                    end else begin
                        m_err[1] = 1;
                    end
                end
            end else if (dl) begin
                m_load = 1; m_cnt = 0; m_err = 0; m_done = 0; m_age = -1;
            end else if (m_age >= 0 && m_age < HOLD) begin
                m_age++;
            end
            e_core = rst_req || !(!m_load && m_age == HOLD) || !m_done;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("outputs{we,core_reset,done,err,cnt}",
                {rom_we, core_reset, load_done, load_err, byte_cnt},
                {e_we, e_core, m_done, m_err, 18'(m_cnt)});
            if (e_we != 0)
                chk("write{addr,data}", {rom_addr, rom_data}, {17'(e_addr), 8'(e_data)});
            for (int i = 0; i < 4; i++) if (rom_we[i] === 1'b1) rcnt[i]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        dl_wr   = 1'b1;
        dl_addr = ADDR_W'(a);
        dl_data = 8'(d);
        tick();
        dl_wr   = 1'b0;
        dl_data = 8'($urandom);
    endtask

    // Sequential image load of n bytes (data = addr[7:0]); dl left low.
    task automatic load_seq(input int n, input bit ovf, input int gap_pct);
        dl = 1'b1;
        tick();
        for (int a = 0; a < n; a++) begin
            wr(a, a & 'hFF);
            if (a == 'h3000) begin
                chk("rom_we@3000", rom_we, 4'b0100);
                chk("rom_addr@3000", rom_addr, 0);
            end
            if (int'($urandom_range(99)) < gap_pct) repeat ($urandom_range(3, 1)) tick();
        end
        if (ovf) begin
            wr('h4000, 'h5A);
            chk("ovf no strobe", rom_we, 0);
            chk("ovf err bit", load_err[1], 1);
            chk("ovf byte_cnt", byte_cnt, 'h4000);
        end
        dl = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, hi;
        reset = 1; rst_req = 0; dl = 0; dl_wr = 0; dl_addr = '0; dl_data = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset rom_we", rom_we, 0);
        chk("reset core_reset", core_reset, 1);
        chk("reset byte_cnt", byte_cnt, 0);
        chk("reset load_err/done", {load_err, load_done}, 0);
        reset = 0;
        repeat (5) tick();

        // Full load
        foreach (rcnt[i]) rcnt[i] = 0;
        load_seq('h4000, 1'b0, 5);
        k = 0;
        while (core_reset !== 1'b0 && k < 3000) begin tick(); k++; end
        chk("core_reset fall delay", k, 1025);
        chk("rgn0 strobes", rcnt[0], 'h2000);
        chk("rgn1 strobes", rcnt[1], 'h1000);
        chk("rgn2 strobes", rcnt[2], 'h800);
        chk("rgn3 strobes", rcnt[3], 'h800);
        chk("full load_done", load_done, 1);
        chk("full load_err", load_err, 0);
        chk("full byte_cnt", byte_cnt, 'h4000);

        // rst_req pulse in RUN
        hi = 0;
        rst_req = 1;
        repeat (3) begin tick(); hi += int'(core_reset); end
        rst_req = 0;
        repeat (3) begin tick(); hi += int'(core_reset); end
        chk("rst_req pulse width", hi, 3);
        chk("rst_req keeps load_done", load_done, 1);

        // Short load
        load_seq('h3FFF, 1'b0, 0);
        repeat (1100) tick();
        chk("short load_err", load_err, 2'b01);
        chk("short load_done", load_done, 0);
        chk("short core_reset", core_reset, 1);

        // Overflow load, then reload during HOLD
        load_seq('h4000, 1'b1, 0);
        repeat (499) tick();
        chk("ovf load_done", load_done, 0);
        dl = 1'b1;
        tick();
        chk("reload byte_cnt", byte_cnt, 0);
        chk("reload load_err", load_err, 0);
        chk("reload core_reset", core_reset, 1);
        for (int i = 0; i < 100; i++) wr(int'($urandom_range('h4100)), int'($urandom));

        // Reset mid-LOAD with a coincident write
        reset = 1; dl_wr = 1; dl_addr = ADDR_W'(5); dl_data = 8'hA5;
        tick();
        chk("midreset rom_we", rom_we, 0);
        chk("midreset addr/data", {rom_addr, rom_data}, 0);
        chk("midreset cnt/err/done", {byte_cnt, load_err, load_done}, 0);
        chk("midreset core_reset", core_reset, 1);
        reset = 0; dl_wr = 0; dl = 0;
        repeat (20) tick();

        // Randomized loads
        for (int r = 0; r < 6; r++) begin
            dl = 1'b1;
            tick();
            repeat ($urandom_range(300, 1)) begin
                rst_req = ($urandom_range(15) == 0);
                if ($urandom_range(3) != 0) begin
                    int a;
                    a = ($urandom_range(9) == 0) ? int'($urandom_range('h4200, 'h4000))
                                                 : int'($urandom_range('h3FFF));
                    wr(a, int'($urandom));
                end else tick();
            end
            dl = 1'b0;
            repeat ($urandom_range(1200, 10)) begin
                rst_req = ($urandom_range(15) == 0);
                dl_wr   = ($urandom_range(7) == 0);
                dl_addr = ADDR_W'($urandom_range('h3FFF));
                tick();
            end
            dl_wr = 0; rst_req = 0;
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
